div_result_display: RTL and testbench



---
 rtl/div_display_pkg.sv | 31 +++
 rtl/bcd_dd7.sv | 49 ++++
 rtl/div_result_display.sv | 154 +++++++++++++++
 tb/tb_div_result_display.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/div_display_pkg.sv
// Shared types, constants and the BCD-to-segment decoder for the divider result display.
package div_display_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int unsigned NUM_DIGITS = 6;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 is shown blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_dd7.sv
// One-bit-per-clock double-dabble for a 7-bit binary value into 3 BCD digits.
module bcd_dd7 (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [6:0]  bin_in,
    output logic [11:0] step_bcd
);

    logic [6:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [11:0] adj;
    logic [18:0] shifted;

    // step_bcd is the working BCD after the current step, so the parent can
    // latch the final result on the same edge as the last iteration.
    always_comb begin
        adj = bcd_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted  = {adj, bin_q} << 1;
        step_bcd = shifted[18:7];

        bin_d = bin_q;
        bcd_d = bcd_q;
        if (load) begin
            bin_d = bin_in;
            bcd_d = '0;
        end else if (step) begin
            bin_d = shifted[6:0];
            bcd_d = step_bcd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
        end
    end

endmodule

// File: rtl/div_result_display.sv
// Captures divider quotient/remainder, converts both to BCD and scans them onto
// a 6-digit common-anode 7-segment display (quotient left, remainder right).
module div_result_display
    import div_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        done_in,
    input  logic [6:0]  q_in,
    input  logic [6:0]  r_in,
    output logic        busy,
    output logic        bcd_valid,
    output logic [11:0] bcd_q,
    output logic [11:0] bcd_r,
    output logic [5:0]  an,
    output logic [6:0]  seg
);

    localparam int unsigned RW = $clog2(REFRESH_DIV);

    state_t      state_q, state_d;
    logic [2:0]  iter_q, iter_d;
    logic        valid_q, valid_d;
    logic [11:0] quo_bcd_q, quo_bcd_d;
    logic [11:0] rem_bcd_q, rem_bcd_d;
    logic [11:0] q_step, r_step;
    logic        load, step;

    logic [RW-1:0] ref_q, ref_d;
    logic [2:0]    idx_q, idx_d;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    digit;
    logic          blank;

    bcd_dd7 u_dd_q (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .bin_in   (q_in),
        .step_bcd (q_step)
    );

    bcd_dd7 u_dd_r (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .bin_in   (r_in),
        .step_bcd (r_step)
    );

    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        valid_d   = 1'b0;
        quo_bcd_d = quo_bcd_q;
        rem_bcd_d = rem_bcd_q;
        load      = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                if (done_in) begin
                    load    = 1'b1;
                    iter_d  = 3'd7;
                    state_d = CONV;
                end
            end
            CONV: begin
                step   = 1'b1;
                iter_d = iter_q - 3'd1;
                if (iter_q == 3'd1) begin
                    quo_bcd_d = q_step;
                    rem_bcd_d = r_step;
                    valid_d   = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Blanking looks only at the published result, never the working registers.
    always_comb begin
        ref_d = ref_q + RW'(1);
        idx_d = idx_q;
        if (ref_q == RW'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? '0 : idx_q + 3'd1;
        end

        digit = 4'hF;
        blank = 1'b0;
        case (idx_q)
            3'd0: digit = rem_bcd_q[3:0];
            3'd1: begin
                digit = rem_bcd_q[7:4];
                blank = (rem_bcd_q[11:4] == 8'd0);
            end
            3'd2: begin
                digit = rem_bcd_q[11:8];
                blank = (rem_bcd_q[11:8] == 4'd0);
            end
            3'd3: digit = quo_bcd_q[3:0];
            3'd4: begin
                digit = quo_bcd_q[7:4];
                blank = (quo_bcd_q[11:4] == 8'd0);
            end
            3'd5: begin
                digit = quo_bcd_q[11:8];
                blank = (quo_bcd_q[11:8] == 4'd0);
            end
            default: blank = 1'b1;
        endcase
        seg_d = (BLANK_LZ && blank) ? SEG_BLANK : seg_decode(digit);
        an_d  = ~(6'd1 << idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            iter_q    <= '0;
            valid_q   <= 1'b0;
            quo_bcd_q <= '0;
            rem_bcd_q <= '0;
            ref_q     <= '0;
            idx_q     <= '0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            valid_q   <= valid_d;
            quo_bcd_q <= quo_bcd_d;
            rem_bcd_q <= rem_bcd_d;
            ref_q     <= ref_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign busy      = (state_q == CONV);
    assign bcd_valid = valid_q;
    assign bcd_q     = quo_bcd_q;
    assign bcd_r     = rem_bcd_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_div_result_display.sv
// Cycle-by-cycle comparison of div_result_display against a decimal-arithmetic model.
module tb_div_result_display;

    localparam int unsigned RDIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        done_in;
    logic [6:0]  q_in;
    logic [6:0]  r_in;
    logic        busy;
    logic        bcd_valid;
    logic [11:0] bcd_q;
    logic [11:0] bcd_r;
    logic [5:0]  an;
    logic [6:0]  seg;

    div_result_display #(
        .REFRESH_DIV (RDIV),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .done_in   (done_in),
        .q_in      (q_in),
        .r_in      (r_in),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .bcd_q     (bcd_q),
        .bcd_r     (bcd_r),
        .an        (an),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model state: published decimal results, pending capture, cycles left in conversion.
    int          m_qv = 0, m_rv = 0;
    int          pend_q = 0, pend_r = 0;
    int          remain = 0;
    bit          m_valid = 1'b0;
    int          scan_n = 0;
    logic [5:0]  exp_an;
    logic [6:0]  exp_seg;
    int          vcount = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_code(input int d);
        logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction

    // Digit index i: 0..2 remainder units..hundreds, 3..5 quotient units..hundreds.
    function automatic logic [6:0] exp_digit_seg(input int i, input int qv, input int rv);
        int val, p, d;
        val = (i >= 3) ? qv : rv;
        p   = i % 3;
        d   = (p == 0) ? val % 10 : (p == 1) ? (val / 10) % 10 : val / 100;
        if ((p == 2 && val < 100) || (p == 1 && val < 10)) return 7'h7F;
        return seg_code(d);
    endfunction

    task automatic cycle(input bit r, input bit d, input int qv, input int rv);
        int idx;
        rst     = r;
        done_in = d;
        q_in    = 7'(qv);
        r_in    = 7'(rv);
        @(posedge clk);
        #1;
        if (r) begin
            remain  = 0;
            m_valid = 1'b0;
            m_qv    = 0;
            m_rv    = 0;
            scan_n  = 0;
            exp_an  = 6'h3F;
            exp_seg = 7'h7F;
        end else begin
            scan_n++;
            idx     = ((scan_n - 1) / RDIV) % 6;
            exp_an  = ~(6'd1 << idx);
            exp_seg = exp_digit_seg(idx, m_qv, m_rv);
            m_valid = 1'b0;
            if (remain > 0) begin
                remain--;
                if (remain == 0) begin
                    m_valid = 1'b1;
                    m_qv    = pend_q;
                    m_rv    = pend_r;
                end
            end else if (d) begin
                remain = 7;
                pend_q = qv;
                pend_r = rv;
            end
        end
        if (bcd_valid === 1'b1) vcount++;
        check("busy",  32'(busy),      32'(remain > 0));
        check("valid", 32'(bcd_valid), 32'(m_valid));
        check("bcd_q", 32'(bcd_q),     32'(to_bcd(m_qv)));
        check("bcd_r", 32'(bcd_r),     32'(to_bcd(m_rv)));
        check("an",    32'(an),        32'(exp_an));
        check("seg",   32'(seg),       32'(exp_seg));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; done_in = 1'b0; q_in = '0; r_in = '0;

        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 0, 0);
        check("rst_an",  32'(an),  32'h3F);
        check("rst_seg", 32'(seg), 32'h7F);
        idle(1);
        check("scan0_an",  32'(an),  32'h3E);
        check("scan0_seg", 32'(seg), 32'h40);

        cycle(1'b0, 1'b1, 127, 0);
        idle(6);
        check("lat_no_early", 32'(bcd_valid), 32'h0);
        idle(1);
        check("lat_valid", 32'(bcd_valid), 32'h1);
        check("q127", 32'(bcd_q), 32'h127);
        check("r0",   32'(bcd_r), 32'h000);

        cycle(1'b0, 1'b1, 100, 99);
        idle(8);
        check("q100", 32'(bcd_q), 32'h100);
        check("r99",  32'(bcd_r), 32'h099);
        cycle(1'b0, 1'b1, 0, 9);
        idle(8);
        check("q0", 32'(bcd_q), 32'h000);
        check("r9", 32'(bcd_r), 32'h009);

        vcount = 0;
        cycle(1'b0, 1'b1, 64, 0);
        idle(2);
        cycle(1'b0, 1'b1, 5, 0);
        idle(10);
        check("coll_vcnt", 32'(vcount), 32'd1);
        check("coll_q",    32'(bcd_q),  32'h064);

        // Back-to-back: done_in held high, re-captured only after the result lands.
        for (int k = 0; k < 9; k++) cycle(1'b0, 1'b1, 33 + k, k);
        idle(8);

        cycle(1'b0, 1'b1, 7, 12);
        idle(8 + 6 * RDIV * 2);
        check("q7",  32'(bcd_q), 32'h007);
        check("r12", 32'(bcd_r), 32'h012);

        vcount = 0;
        cycle(1'b0, 1'b1, 50, 3);
        idle(3);
        cycle(1'b1, 1'b0, 0, 0);
        idle(10);
        check("abort_vcnt", 32'(vcount), 32'd0);
        check("abort_q",    32'(bcd_q),  32'h000);
        cycle(1'b0, 1'b1, 42, 1);
        idle(8);
        check("q42", 32'(bcd_q), 32'h042);

        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 127)),
                  int'($urandom_range(0, 127)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
